// File: rtl/uart_rx_top.sv
// UART receiver: 16x oversampled, 8 data bits LSB first, optional even parity, one stop bit.
// Define RX_MAJORITY_VOTE_EN to make each bit decision a 2-of-3 vote over sample counts 7, 8 and 9.
module uart_rx_top #(
    parameter int unsigned CLKS_PER_TICK = 27,
    parameter int unsigned OVERSAMPLE    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       p_sel,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy,
    output logic       baud_wire
);

    localparam int unsigned DIV_W    = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [3:0]  SMP_LAST = 4'(OVERSAMPLE - 1);
`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [3:0]  SMP_POINT = 4'd9;
`else
    localparam logic [3:0]  SMP_POINT = 4'd7;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_rx_meta;
    logic               r_rx_s;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [3:0]         r_smp_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_psel;
    logic               r_par_bit;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_par_err;
    logic               r_frm_err;
    logic               r_busy;
    logic               r_baud;

    logic               w_tick;
    logic               w_smp_tick;
    logic               w_smp_bit;
    logic               w_clr_cnt;
    logic               w_shift;
    logic               w_par_smp;
    logic               w_load;

    // Two-flop synchronizer; the idle-high line resets to 1
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick     = (r_div_cnt == DIV_W'(CLKS_PER_TICK - 1));
    assign w_smp_tick = w_tick && (r_smp_cnt == SMP_POINT);

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] r_hist;

    // Keeps the two previous tick samples so the vote completes at count 9
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= 2'b11;
        end else if (w_tick) begin
            r_hist <= {r_hist[0], r_rx_s};
        end
    end

    assign w_smp_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rx_s) | (r_hist[0] & r_rx_s);
`else
    assign w_smp_bit = r_rx_s;
`endif

    // Tick divider and sample counter, realigned to the start edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_smp_cnt <= 4'd0;
            r_baud    <= 1'b0;
        end else begin
            r_baud <= w_tick;
            if (w_clr_cnt || w_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (w_clr_cnt) begin
                r_smp_cnt <= 4'd0;
            end else if (w_tick) begin
                r_smp_cnt <= (r_smp_cnt == SMP_LAST) ? 4'd0 : r_smp_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clr_cnt    = 1'b0;
        w_shift      = 1'b0;
        w_par_smp    = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_next_state = S_START;
                    w_clr_cnt    = 1'b1;
                end
            end
            S_START: begin
                if (w_smp_tick) begin
                    w_next_state = w_smp_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_smp_tick) begin
                    w_shift = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_next_state = r_psel ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_smp_tick) begin
                    w_par_smp    = 1'b1;
                    w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (w_smp_tick) begin
                    w_load       = 1'b1;
                    w_next_state = w_smp_bit ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (r_rx_s) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Frame datapath: shift register, bit index and latched frame options
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_psel    <= 1'b0;
            r_par_bit <= 1'b0;
        end else begin
            if (w_clr_cnt) begin
                r_bit_idx <= 3'd0;
                r_psel    <= p_sel;
            end else if (w_shift) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_shift) begin
                r_shift <= {w_smp_bit, r_shift[7:1]};
            end
            if (w_par_smp) begin
                r_par_bit <= w_smp_bit;
            end
        end
    end

    // Result registers hold until the next completed frame
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data    <= 8'd0;
            r_valid   <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= w_load;
            r_busy  <= (w_next_state != S_IDLE);
            if (w_load) begin
                r_data    <= r_shift;
                r_par_err <= r_psel & ((^r_shift) ^ r_par_bit);
                r_frm_err <= ~w_smp_bit;
            end
        end
    end

    assign data_out   = r_data;
    assign rx_valid   = r_valid;
    assign parity_err = r_par_err;
    assign frame_err  = r_frm_err;
    assign busy       = r_busy;
    assign baud_wire  = r_baud;

endmodule
